trojan_trigger_seq_gen: RTL and testbench

// - Transmit-side counterpart of the AES trigger-sequence detector: drives an ordered

---
 rtl/trojan_trigger_seq_gen.sv | 126 ++++++++++++
 tb/tb_trojan_trigger_seq_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/trojan_trigger_seq_gen.sv
// Trigger-sequence generator: offers SEQ0..SEQ3 over a valid/ready handshake,
// with an optional idle gap between words. start/abort come from the harness.
module trojan_trigger_seq_gen #(
  parameter logic [127:0] SEQ0       = 128'h3243f6a8_885a308d_313198a2_e0370734,
  parameter logic [127:0] SEQ1       = 128'h00112233_44556677_8899aabb_ccddeeff,
  parameter logic [127:0] SEQ2       = 128'h0,
  parameter logic [127:0] SEQ3       = 128'h1,
  parameter int unsigned  GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   step,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam bit         NO_GAP   = (GAP_CYCLES == 0);
  localparam logic [7:0] GAP_LOAD = NO_GAP ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_e       state_q, state_d;
  logic [1:0]   step_q, step_d;
  logic [7:0]   gap_q, gap_d;
  logic [127:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         hs;

  assign hs = valid_q & out_ready;

  // State register; outputs are registered alongside, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        step_d = '0;
        if (start) state_d = SEND;
      end
      SEND: begin
        if (hs) begin
          if (step_q == 2'd3) begin
            state_d = FIN;
            step_d  = '0;
          end else begin
            step_d = step_q + 2'd1;
            if (!NO_GAP) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = SEND;
        else             gap_d   = gap_q - 8'd1;
      end
      FIN: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    // abort beats everything except reset, including a same-cycle start in IDLE.
    if (abort) begin
      state_d = IDLE;
      step_d  = '0;
      gap_d   = '0;
    end
  end

  always_comb begin
    valid_d = (state_d == SEND);
    busy_d  = (state_d == SEND) || (state_d == GAP);
    done_d  = (state_d == FIN);
    data_d  = '0;
    if (state_d == SEND) begin
      unique case (step_d)
        2'd0:    data_d = SEQ0;
        2'd1:    data_d = SEQ1;
        2'd2:    data_d = SEQ2;
        default: data_d = SEQ3;
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign step      = step_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trojan_trigger_seq_gen.sv
// Directed bench for trojan_trigger_seq_gen: per-cycle expectations are queued
// when inputs are driven and compared after the following clock edge.
module tb_trojan_trigger_seq_gen;

  localparam logic [127:0] S0 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] S1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] S2 = 128'h0;
  localparam logic [127:0] S3 = 128'h1;
  localparam logic [127:0] Z  = 128'h0;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready;
  logic sel;

  logic [127:0] d2, d0;
  logic         v2, v0, b2, b0, dn2, dn0;
  logic [1:0]   s2, s0;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic [1:0]   s;
    logic         b;
    logic         dn;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  trojan_trigger_seq_gen dut_g2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .out_data(d2), .out_valid(v2), .out_ready(out_ready),
    .step(s2), .busy(b2), .done(dn2)
  );

  trojan_trigger_seq_gen #(.GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .out_data(d0), .out_valid(v0), .out_ready(out_ready),
    .step(s0), .busy(b0), .done(dn0)
  );

  task automatic tick(input logic r, input logic st, input logic ab, input logic rdy,
                      input logic ev, input logic [127:0] ed, input logic [1:0] es,
                      input logic eb, input logic edn, input string tag);
    exp_t e;
    logic [132:0] obs, expv;
    e.v = ev; e.d = ed; e.s = es; e.b = eb; e.dn = edn; e.tag = tag;
    exp_q.push_back(e);
    rst = r; start = st; abort = ab; out_ready = rdy;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    obs  = sel ? {v0, d0, s0, b0, dn0} : {v2, d2, s2, b2, dn2};
    expv = {e.v, e.d, e.s, e.b, e.dn};
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed {v,data,step,busy,done}=%h expected=%h", e.tag, obs, expv);
    end
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;

    // GAP_CYCLES=2, ready high: words at c1, c4, c7, c10, done at c11
    tick(1,0,0,0, 0,Z ,0,0,0, "reset");
    tick(0,1,0,1, 1,S0,0,1,0, "g2_c1_seq0");
    tick(0,0,0,1, 0,Z ,1,1,0, "g2_c2_gap");
    tick(0,0,0,1, 0,Z ,1,1,0, "g2_c3_gap");
    tick(0,0,0,1, 1,S1,1,1,0, "g2_c4_seq1");
    tick(0,1,0,1, 0,Z ,2,1,0, "g2_c5_gap_start_ignored");
    tick(0,0,0,1, 0,Z ,2,1,0, "g2_c6_gap");
    tick(0,0,0,1, 1,S2,2,1,0, "g2_c7_seq2");
    tick(0,0,0,1, 0,Z ,3,1,0, "g2_c8_gap");
    tick(0,0,0,1, 0,Z ,3,1,0, "g2_c9_gap");
    tick(0,0,0,1, 1,S3,3,1,0, "g2_c10_seq3");
    tick(0,0,0,1, 0,Z ,0,0,1, "g2_c11_done");
    tick(0,1,0,1, 0,Z ,0,0,0, "g2_start_in_fin_ignored");
    tick(0,0,0,1, 0,Z ,0,0,0, "g2_idle_after");

    // back-pressure on SEQ0 and SEQ1, then abort during the gap after SEQ1
    tick(0,1,0,0, 1,S0,0,1,0, "bp_seq0");
    tick(0,0,0,0, 1,S0,0,1,0, "bp_hold_seq0");
    tick(0,0,0,1, 0,Z ,1,1,0, "bp_gap_a");
    tick(0,0,0,1, 0,Z ,1,1,0, "bp_gap_b");
    tick(0,0,0,0, 1,S1,1,1,0, "bp_seq1");
    for (int unsigned i = 0; i < 5; i++)
      tick(0,0,0,0, 1,S1,1,1,0, "bp_hold_seq1");
    tick(0,0,0,1, 0,Z ,2,1,0, "bp_gap_after_seq1");
    tick(0,0,1,1, 0,Z ,0,0,0, "abort_in_gap");
    tick(0,0,0,1, 0,Z ,0,0,0, "abort_no_done_a");
    tick(0,0,0,1, 0,Z ,0,0,0, "abort_no_done_b");

    // abort coinciding with a handshake: no further words, no done
    tick(0,1,0,1, 1,S0,0,1,0, "abhs_seq0");
    tick(0,0,1,1, 0,Z ,0,0,0, "abhs_abort");
    tick(0,0,0,1, 0,Z ,0,0,0, "abhs_idle");

    // start and abort together in IDLE
    tick(0,1,1,1, 0,Z ,0,0,0, "start_abort_idle");
    tick(0,0,0,1, 0,Z ,0,0,0, "start_abort_stays_idle");

    // reset mid-sequence overrides a simultaneous start
    tick(0,1,0,0, 1,S0,0,1,0, "rstmid_seq0");
    tick(1,1,0,0, 0,Z ,0,0,0, "rstmid_reset");
    tick(0,0,0,1, 0,Z ,0,0,0, "rstmid_idle");

    // GAP_CYCLES=0: back-to-back words, one stall on SEQ1
    sel = 1'b1;
    tick(1,0,0,0, 0,Z ,0,0,0, "g0_reset");
    tick(0,1,0,1, 1,S0,0,1,0, "g0_seq0");
    tick(0,0,0,1, 1,S1,1,1,0, "g0_seq1");
    tick(0,0,0,0, 1,S1,1,1,0, "g0_hold_seq1");
    tick(0,0,0,1, 1,S2,2,1,0, "g0_seq2");
    tick(0,0,0,1, 1,S3,3,1,0, "g0_seq3");
    tick(0,0,0,1, 0,Z ,0,0,1, "g0_done");
    tick(0,0,0,1, 0,Z ,0,0,0, "g0_idle");

    // GAP_CYCLES=0 at full throughput: four consecutive valid cycles
    tick(0,1,0,1, 1,S0,0,1,0, "g0f_seq0");
    tick(0,0,0,1, 1,S1,1,1,0, "g0f_seq1");
    tick(0,0,0,1, 1,S2,2,1,0, "g0f_seq2");
    tick(0,0,0,1, 1,S3,3,1,0, "g0f_seq3");
    tick(0,0,0,1, 0,Z ,0,0,1, "g0f_done");
    tick(0,0,0,1, 0,Z ,0,0,0, "g0f_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
